// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the code-sequence tracker.
// The default sequence is the 3-bit Gray walk 0,1,3,2,6,7,5,4.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } trk_state_e;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Entry i sits at bits [i*3 +: 3].
  function automatic logic [23:0] gray_seq8();
    logic [23:0] s;
    logic [7:0]  g;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      g = gray(8'(i));
      s[i*3 +: 3] = g[2:0];
    end
    return s;
  endfunction

  localparam logic [23:0] GRAY_SEQ = gray_seq8();

endpackage

// File: rtl/fsm_seq_lookup.sv
// Combinational reverse lookup of a code in the sequence table.
// On duplicates the lowest index wins.
module fsm_seq_lookup #(
  parameter int WIDTH   = 3,
  parameter int SEQ_LEN = 8,
  localparam int PW     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic [WIDTH-1:0]         q_in,
  input  logic [SEQ_LEN*WIDTH-1:0] seq,
  output logic                     hit,
  output logic [PW-1:0]            idx
);

  // Scan high to low so the last (lowest) match overwrites earlier ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SEQ_LEN - 1; i >= 0; i--) begin
      if (seq[i*WIDTH +: WIDTH] == q_in) begin
        hit = 1'b1;
        idx = PW'(i);
      end
    end
  end

endmodule

// File: rtl/fsm_seq_tracker.sv
// Acquires lock on a cyclic code stream, predicts the next code, and counts
// deviations while locked; drops lock after MISS_LIMIT consecutive misses.
module fsm_seq_tracker
  import fsm_seq_pkg::*;
#(
  parameter int                         WIDTH      = 3,
  parameter int                         SEQ_LEN    = 8,
  parameter logic [SEQ_LEN*WIDTH-1:0]   SEQ        = GRAY_SEQ,
  parameter int                         LOCK_COUNT = 3,
  parameter int                         MISS_LIMIT = 2,
  localparam int                        PW         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [PW-1:0]    pos,
  output logic [WIDTH-1:0] expected
);

  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int XCW = $clog2(MISS_LIMIT + 1);

  trk_state_e     state;
  logic [MCW-1:0] match_cnt;
  logic [XCW-1:0] miss_cnt;
  logic [PW-1:0]  pos_nxt;
  logic [MCW-1:0] match_inc;
  logic [XCW-1:0] miss_inc;
  logic           hit;
  logic [PW-1:0]  idx;
  logic           match;
  logic           miss_locked;

  // Explicit wrap keeps non-power-of-two lengths correct.
  assign pos_nxt     = (pos == PW'(SEQ_LEN - 1)) ? '0 : pos + 1'b1;
  assign expected    = SEQ[pos_nxt*WIDTH +: WIDTH];
  assign match       = (q_in == expected);
  assign match_inc   = match_cnt + 1'b1;
  assign miss_inc    = miss_cnt + 1'b1;
  assign miss_locked = q_valid && (state == LOCKED) && !match;

  fsm_seq_lookup #(
    .WIDTH   (WIDTH),
    .SEQ_LEN (SEQ_LEN)
  ) u_lookup (
    .q_in (q_in),
    .seq  (SEQ),
    .hit  (hit),
    .idx  (idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      pos       <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (q_valid) begin
        case (state)
          HUNT: begin
            if (hit) begin
              pos       <= idx;
              match_cnt <= '0;
              state     <= SYNC;
            end
          end
          SYNC: begin
            if (match) begin
              pos       <= pos_nxt;
              match_cnt <= match_inc;
              if (match_inc == MCW'(LOCK_COUNT)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (hit) begin
              // Re-anchor on the same sample rather than losing a cycle in HUNT.
              pos       <= idx;
              match_cnt <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            pos <= pos_nxt;
            if (match) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_inc;
              if (miss_inc == XCW'(MISS_LIMIT)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
      if (err_clr)
        err_count <= '0;
      else if (miss_locked && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fsm_seq_tracker.sv
// Bench for fsm_seq_tracker: table-driven vectors through an expectation queue,
// plus hand sequences for reset, SYNC re-anchor, gaps and saturation.
module tb_fsm_seq_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] q_in = '0;
  logic       q_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [2:0] pos;
  logic [2:0] expected;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       vld;
    logic [2:0] q;
    logic       clr;
    logic       lk;
    logic       pl;
    logic [7:0] cnt;
    logic [2:0] pos;
  } vec_t;

  vec_t expq[$];
  vec_t tbl [19];
  logic [2:0] seq_tb [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  fsm_seq_tracker dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .pos       (pos),
    .expected  (expected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lk, input int pl, input int cnt, input int p);
    chk({tag, ".locked"}, locked, lk);
    chk({tag, ".err_pulse"}, err_pulse, pl);
    chk({tag, ".err_count"}, err_count, cnt);
    chk({tag, ".pos"}, pos, p);
    chk({tag, ".expected"}, expected, seq_tb[(p + 1) % 8]);
  endtask

  // Drive one sample, queue its expectation, compare once the edge has passed.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    q_valid = v.vld;
    q_in    = v.q;
    err_clr = v.clr;
    expq.push_back(v);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    chk_all(tag, e.lk, e.pl, e.cnt, e.pos);
    q_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic run(input int vld, input int q, input int clr, input int lk,
                     input int pl, input int cnt, input int p, input string tag);
    vec_t v;
    v.vld = vld[0];  v.q = q[2:0];  v.clr = clr[0];
    v.lk  = lk[0];   v.pl = pl[0];  v.cnt = cnt[7:0];  v.pos = p[2:0];
    apply(v, tag);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #2;
    chk_all(tag, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int c;
    // vld q clr | locked pulse count pos
    tbl = '{
      '{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3},  // clean lock
      '{1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd0, 3'd4},
      '{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd0, 3'd5},
      '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'd0, 3'd6},
      '{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0, 3'd7},
      '{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0},
      '{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'd1, 3'd1},  // single glitch, flywheel
      '{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd1, 3'd2},
      '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd1, 3'd3},
      '{1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'd2, 3'd4},  // two misses -> loss
      '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'd3, 3'd5},
      '{1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd3, 3'd1},  // reacquire
      '{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'd3, 3'd2},
      '{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 3'd3},
      '{1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 8'd3, 3'd4},
      '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'd0, 3'd5},  // clear beats increment
      '{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'd0, 3'd6},
      '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd6},  // invalid cycles are inert
      '{1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0, 3'd6}
    };

    repeat (3) @(posedge clk);
    #1;
    chk_all("rst", 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Async reset between edges while locked with a nonzero count.
    run(1, 0, 0, 1, 1, 1, 7, "pre_rst");
    reset_pulse("async_rst");

    // SYNC mismatch re-anchors on the same sample.
    run(1, 0, 0, 0, 0, 0, 0, "sm0");
    run(1, 1, 0, 0, 0, 0, 1, "sm1");
    run(1, 6, 0, 0, 0, 0, 4, "sm_re");
    run(1, 7, 0, 0, 0, 0, 5, "sm2");
    run(1, 5, 0, 0, 0, 0, 6, "sm3");
    run(1, 4, 0, 1, 0, 0, 7, "sm_lock");

    // Gaps during SYNC do not disturb match counting.
    reset_pulse("rst2");
    run(1, 0, 0, 0, 0, 0, 0, "g0");
    run(0, 5, 0, 0, 0, 0, 0, "g_gap0");
    run(1, 1, 0, 0, 0, 0, 1, "g1");
    run(0, 7, 0, 0, 0, 0, 1, "g_gap1");
    run(0, 7, 0, 0, 0, 0, 1, "g_gap2");
    run(1, 3, 0, 0, 0, 0, 2, "g2");
    run(0, 4, 0, 0, 0, 0, 2, "g_gap3");
    run(1, 2, 0, 1, 0, 0, 3, "g_lock");

    // Gap between misses while locked keeps the miss count.
    run(1, 0, 0, 1, 1, 1, 4, "lm0");
    run(0, 0, 0, 1, 0, 1, 4, "lm_gap");
    run(1, 0, 0, 0, 1, 2, 5, "lm_loss");

    // Saturation: 150 lock/double-miss bursts = 300 mismatches.
    reset_pulse("rst3");
    c = 0;
    for (int b = 0; b < 150; b++) begin
      run(1, 0, 0, 0, 0, c, 0, "sat_a");
      run(1, 1, 0, 0, 0, c, 1, "sat_b");
      run(1, 3, 0, 0, 0, c, 2, "sat_c");
      run(1, 2, 0, 1, 0, c, 3, "sat_d");
      c = (c + 1 > 255) ? 255 : c + 1;
      run(1, 0, 0, 1, 1, c, 4, "sat_m1");
      c = (c + 1 > 255) ? 255 : c + 1;
      run(1, 0, 0, 0, 1, c, 5, "sat_m2");
    end
    chk("sat_final", err_count, 255);

    // Clear coincident with a mismatch at saturation.
    run(1, 0, 0, 0, 0, 255, 0, "clr_a");
    run(1, 1, 0, 0, 0, 255, 1, "clr_b");
    run(1, 3, 0, 0, 0, 255, 2, "clr_c");
    run(1, 2, 0, 1, 0, 255, 3, "clr_d");
    run(1, 0, 1, 1, 1, 0, 4, "clr_miss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
